// File: rtl/ext_pipe_pkg.sv
// ext_pkg: shared Op encodings for the immediate-extension unit.
// Optional feature macro used by this slice: EXT_PIPE_OVF_CHECK_EN.
package ext_pkg;

  typedef logic [2:0] ext_op_t;

  localparam ext_op_t EXT_SEXT = 3'b000;  // sign-extend
  localparam ext_op_t EXT_ZEXT = 3'b001;  // zero-extend
  localparam ext_op_t EXT_HIGH = 3'b010;  // field into the top bits (lui)
  localparam ext_op_t EXT_SSHL = 3'b011;  // sign-extend then shift left
  localparam ext_op_t EXT_ZSHL = 3'b100;  // zero-extend then shift left (jump target)

  // Encodings above EXT_ZSHL are reserved and flagged as errors.
  function automatic logic ext_op_legal(ext_op_t op);
    return op <= EXT_ZSHL;
  endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: valid/ready input and output channels of ext_pipe.
// With EXT_PIPE_OVF_CHECK_EN defined the output channel also carries out_ovf.
interface ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) ();
  import ext_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  In;
  ext_op_t          Op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Out;
  logic             out_err;
`ifdef EXT_PIPE_OVF_CHECK_EN
  logic             out_ovf;
`endif

  // Producer of immediates and consumer of results.
  modport master (
    output in_valid, In, Op, out_ready,
`ifdef EXT_PIPE_OVF_CHECK_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, Out, out_err
  );

  // The extension unit itself.
  modport slave (
    input  in_valid, In, Op, out_ready,
`ifdef EXT_PIPE_OVF_CHECK_EN
    output out_ovf,
`endif
    output in_ready, out_valid, Out, out_err
  );

endinterface

// File: rtl/ext_pipe_core.sv
// ext_core: purely combinational In/Op -> {data, err[, ovf]} extension function.
// With EXT_PIPE_OVF_CHECK_EN defined it also reports bits lost by the shifted modes.
module ext_core import ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  In,
  input  ext_op_t          Op,
  output logic [OUT_W-1:0] data,
  output logic             err
`ifdef EXT_PIPE_OVF_CHECK_EN
  ,
  output logic             ovf
`endif
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] high;
  logic [OUT_W-1:0] sshl;
  logic [OUT_W-1:0] zshl;

  // Sized casts keep every candidate at OUT_W, including IN_W == OUT_W.
  assign sext = OUT_W'($signed(In));
  assign zext = OUT_W'(In);
  assign high = zext << (OUT_W - IN_W);
  assign sshl = sext << SHAMT;
  assign zshl = zext << SHAMT;

`ifdef EXT_PIPE_OVF_CHECK_EN
  // A shift lost information exactly when shifting back does not recover the source.
  logic [OUT_W-1:0] sshl_back;
  logic [OUT_W-1:0] zshl_back;
  assign sshl_back = OUT_W'($signed(sshl) >>> SHAMT);
  assign zshl_back = zshl >> SHAMT;
`endif

  // Select the extension mode; reserved encodings give zero with err set.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    data = '0;
    err  = !ext_op_legal(Op);
`ifdef EXT_PIPE_OVF_CHECK_EN
    ovf  = 1'b0;
`endif
    case (Op)
      EXT_SEXT: data = sext;
      EXT_ZEXT: data = zext;
      EXT_HIGH: data = high;
      EXT_SSHL: begin
        data = sshl;
`ifdef EXT_PIPE_OVF_CHECK_EN
        ovf  = sshl_back != sext;
`endif
      end
      EXT_ZSHL: begin
        data = zshl;
`ifdef EXT_PIPE_OVF_CHECK_EN
        ovf  = zshl_back != zext;
`endif
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extension with a 2-entry (main + skid) output buffer.
// Define EXT_PIPE_OVF_CHECK_EN to register the shift-overflow flag as out_ovf.
module ext_pipe import ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input logic      clk,
  input logic      reset,
  ext_pipe_if.slave bus
);

  logic [OUT_W-1:0] core_data;
  logic             core_err;
  logic             core_ovf;

  ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHAMT(SHAMT)
  ) u_core (
    .In  (bus.In),
    .Op  (bus.Op),
    .data(core_data),
`ifdef EXT_PIPE_OVF_CHECK_EN
    .ovf (core_ovf),
`endif
    .err (core_err)
  );

`ifndef EXT_PIPE_OVF_CHECK_EN
  assign core_ovf = 1'b0;
`endif

  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic             main_err;
  logic             main_ovf;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;
  logic             skid_ovf;
  logic             accept;
  logic             drain;

  // in_ready depends only on a register, so out_ready never reaches it combinationally.
  assign bus.in_ready  = !skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.Out       = main_data;
  assign bus.out_err   = main_err;
`ifdef EXT_PIPE_OVF_CHECK_EN
  assign bus.out_ovf   = main_ovf;
`endif

  assign accept = bus.in_valid && !skid_valid;
  assign drain  = main_valid && bus.out_ready;

  // Main/skid buffer: refill main from skid first, else from the core; overflow into skid.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (reset) begin
      // NOTE: the data registers are reset too, because Out must read zero straight after reset.
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      main_ovf   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      skid_ovf   <= 1'b0;
    end else if (drain || !main_valid) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_err   <= skid_err;
        main_ovf   <= skid_ovf;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_data <= core_data;
          main_err  <= core_err;
          main_ovf  <= core_ovf;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= core_data;
      skid_err   <= core_err;
      skid_ovf   <= core_ovf;
    end
  end

`ifndef EXT_PIPE_OVF_CHECK_EN
  // Without the overflow feature the flag registers are constant and unused.
  logic unused_ovf;
  assign unused_ovf = main_ovf ^ skid_ovf;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and random checks of ext_pipe (IN_W=16, OUT_W=32, SHAMT=2)
// against an arithmetic reference model and an in-flight result queue.
module tb_ext_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  ext_pipe #(
    .IN_W (16),
    .OUT_W(32),
    .SHAMT(2)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Results the DUT currently holds, oldest first: {ovf, err, data}.
  logic [33:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result computed with integer arithmetic on the field's value.
  function automatic logic [33:0] model(input logic [2:0] op, input logic [15:0] in);
    longint sv;
    longint zv;
    longint r;
    logic   err;
    logic   ovf;
    sv  = in[15] ? longint'(in) - 65536 : longint'(in);
    zv  = longint'(in);
    r   = 0;
    err = 1'b0;
    ovf = 1'b0;
    case (op)
      3'd0: r = sv;
      3'd1: r = zv;
      3'd2: r = zv * 65536;
      3'd3: begin
        r   = sv * 4;
        ovf = (r < -(longint'(1) << 31)) || (r >= (longint'(1) << 31));
      end
      3'd4: begin
        r   = zv * 4;
        ovf = r >= (longint'(1) << 32);
      end
      default: err = 1'b1;
    endcase
    return {ovf, err, r[31:0]};
  endfunction

  // Check the DUT against the queue, then clock once and update the queue.
  task automatic step(output bit acc, output bit drn);
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("out_data", 64'(bus.Out), 64'(q[0][31:0]));
      check("out_err", 64'(bus.out_err), 64'(q[0][32]));
`ifdef EXT_PIPE_OVF_CHECK_EN
      check("out_ovf", 64'(bus.out_ovf), 64'(q[0][33]));
`endif
    end
    acc = bus.in_valid && (q.size() < 2);
    drn = bus.out_ready && (q.size() != 0);
    begin
      logic [33:0] nxt;
      nxt = model(bus.Op, bus.In);
      @(posedge clk);
      #1;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(nxt);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.In       = 16'($urandom);
    bus.Op       = 3'($urandom);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out", 64'(bus.Out), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
  endtask

  task automatic directed(input logic [2:0] op, input logic [15:0] in,
                          input logic [31:0] exp_data, input logic exp_err);
    bit a, d;
    bus.Op        = op;
    bus.In        = in;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step(a, d);
    bus.in_valid  = 1'b0;
    check("dir_valid", 64'(bus.out_valid), 64'd1);
    check("dir_data", 64'(bus.Out), 64'(exp_data));
    check("dir_err", 64'(bus.out_err), 64'(exp_err));
    step(a, d);
  endtask

  initial begin
    bit acc, drn;
    int sent;
    int popped;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.In        = '0;
    bus.Op        = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    do_reset();

    // One vector per mode, with constant expected results.
    directed(3'b000, 16'h8001, 32'hFFFF8001, 1'b0);
    directed(3'b001, 16'h8001, 32'h00008001, 1'b0);
    directed(3'b010, 16'h1234, 32'h12340000, 1'b0);
    directed(3'b011, 16'hFFFF, 32'hFFFFFFFC, 1'b0);
    directed(3'b100, 16'hC001, 32'h00030004, 1'b0);
    directed(3'b110, 16'h1234, 32'h00000000, 1'b1);

    // Backpressure: stream 4 inputs, stall the consumer from cycle 1 to 4.
    sent   = 0;
    popped = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.out_ready = (cyc == 0) || (cyc >= 5);
      bus.in_valid  = sent < 4;
      bus.In        = 16'hA000 + 16'(sent);
      bus.Op        = 3'b001;
      if (cyc == 4) check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      step(acc, drn);
      sent   += int'(acc);
      popped += int'(drn);
    end
    check("bp_sent", 64'(sent), 64'd4);
    check("bp_popped", 64'(popped), 64'd4);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);

    // Reset while both registers are full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Op        = 3'b000;
    bus.In        = 16'h8765;
    step(acc, drn);
    bus.In        = 16'h4321;
    step(acc, drn);
    check("full_before_rst", 64'(q.size()), 64'd2);
    do_reset();

    // Random traffic with random backpressure and all Op codes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.In        = 16'($urandom);
      bus.Op        = 3'($urandom);
      step(acc, drn);
    end

    // Bounded drain.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) step(acc, drn);
    check("drained", 64'(q.size()), 64'd0);
    check("end_out_valid", 64'(bus.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
